// File: rtl/ariane_pkg.sv
// Shared core types used by the BHT update queue.
// Contents:
//   NR_COMMIT_PORTS  number of commit ports checked per cycle
//   TRANS_ID_BITS    width of the scoreboard transaction id
//   bht_update_t     {valid, pc, taken} update record sent to the BHT
//   entry_state_e    lifecycle of a queue entry
package ariane_pkg;

  localparam int unsigned NR_COMMIT_PORTS = 2;
  localparam int unsigned TRANS_ID_BITS   = 3;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic        taken;
  } bht_update_t;

  // FREE -> RESOLVED (enqueue) -> COMMITTED (id match) -> FREE (drain)
  typedef enum logic [1:0] {
    FREE      = 2'd0,
    RESOLVED  = 2'd1,
    COMMITTED = 2'd2
  } entry_state_e;

endpackage

// File: rtl/bht_update_queue.sv
// Holds resolved-branch outcomes until the branch commits, then drains them
// one per cycle to the BHT so it only learns from committed branches.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   flush_i              drop every entry that has not committed yet
//   debug_mode_i         ignore new resolutions while in debug mode
//   resolve_*_i          resolved branch {pc, taken, id}, qualified by resolve_valid_i
//   commit_valid_i/id_i  per-port commit acknowledge with scoreboard id
//   bht_update_o         registered {valid, pc, taken} update to the BHT
//   full_o               all DEPTH entries occupied
//   drop_cnt_o           saturating count of resolutions dropped while full
module bht_update_queue
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic                                          flush_i,
  input  logic                                          debug_mode_i,
  input  logic                                          resolve_valid_i,
  input  logic [63:0]                                   resolve_pc_i,
  input  logic                                          resolve_taken_i,
  input  logic [TRANS_ID_BITS-1:0]                      resolve_id_i,
  input  logic [NR_COMMIT_PORTS-1:0]                    commit_valid_i,
  input  logic [NR_COMMIT_PORTS-1:0][TRANS_ID_BITS-1:0] commit_id_i,
  output bht_update_t                                   bht_update_o,
  output logic                                          full_o,
  output logic [15:0]                                   drop_cnt_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  entry_state_e             state_q [DEPTH];
  entry_state_e             state_d [DEPTH];
  logic [63:0]              pc_q    [DEPTH];
  logic                     taken_q [DEPTH];
  logic [TRANS_ID_BITS-1:0] id_q    [DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      drop_q, drop_d;
  bht_update_t      upd_q, upd_d;

  logic                                   full;
  logic                                   wr_en;
  logic                                   drain;
  logic [CNT_W-1:0]                       n_comm;
  logic [DEPTH-1:0][NR_COMMIT_PORTS-1:0]  port_hit;
  logic [DEPTH-1:0]                       commit_hit;

  assign full = (count_q == CNT_W'(DEPTH));

  // Id CAM: every entry is compared against every commit port in parallel.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cam
    for (genvar pi = 0; pi < NR_COMMIT_PORTS; pi++) begin : g_port
      assign port_hit[gi][pi] = commit_valid_i[pi] && (id_q[gi] == commit_id_i[pi]);
    end
    assign commit_hit[gi] = (state_q[gi] == RESOLVED) && (|port_hit[gi]);
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    drop_d  = drop_q;
    upd_d   = '0;
    wr_en   = 1'b0;
    n_comm  = '0;

    // Commit marks are applied first so that flush and drain both see them;
    // this is what gives the 1-cycle commit-to-update latency at head.
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (commit_hit[i]) state_d[i] = COMMITTED;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (state_d[i] == COMMITTED) n_comm = n_comm + CNT_W'(1);
    end

    drain = (state_d[head_q] == COMMITTED);
    if (drain) begin
      upd_d.valid     = 1'b1;
      upd_d.pc        = pc_q[head_q];
      upd_d.taken     = taken_q[head_q];
      state_d[head_q] = FREE;
      head_d          = head_q + PTR_W'(1);
    end

    if (flush_i) begin
      // Committed entries form a contiguous run from head, so the new tail
      // sits right after that run; the same-cycle resolution is discarded.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (state_d[i] == RESOLVED) state_d[i] = FREE;
      end
      tail_d  = head_q + n_comm[PTR_W-1:0];
      count_d = n_comm - CNT_W'(drain);
    end else if (resolve_valid_i && !debug_mode_i) begin
      if (full) begin
        // Full is judged on the current state, even if a drain frees a slot now.
        if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
        count_d = count_q - CNT_W'(drain);
      end else begin
        wr_en           = 1'b1;
        state_d[tail_q] = RESOLVED;
        tail_d          = tail_q + PTR_W'(1);
        count_d         = count_q + CNT_W'(1) - CNT_W'(drain);
      end
    end else begin
      count_d = count_q - CNT_W'(drain);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) state_q[i] <= FREE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      drop_q  <= '0;
      upd_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      drop_q  <= drop_d;
      upd_q   <= upd_d;
    end
  end

  // Payload storage needs no reset: entry state alone decides validity.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      pc_q[tail_q]    <= resolve_pc_i;
      taken_q[tail_q] <= resolve_taken_i;
      id_q[tail_q]    <= resolve_id_i;
    end
  end

  assign bht_update_o = upd_q;
  assign full_o       = full;
  assign drop_cnt_o   = drop_q;

endmodule

// File: tb/tb_bht_update_queue.sv
module tb_bht_update_queue;
  import ariane_pkg::*;

  localparam int DEPTH = 8;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic flush_i = 1'b0;
  logic debug_mode_i = 1'b0;
  logic resolve_valid_i = 1'b0;
  logic [63:0] resolve_pc_i = '0;
  logic resolve_taken_i = 1'b0;
  logic [2:0] resolve_id_i = '0;
  logic [1:0] commit_valid_i = '0;
  logic [1:0][2:0] commit_id_i = '0;
  bht_update_t bht_update_o;
  logic full_o;
  logic [15:0] drop_cnt_o;

  bht_update_queue #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .debug_mode_i(debug_mode_i),
    .resolve_valid_i(resolve_valid_i), .resolve_pc_i(resolve_pc_i),
    .resolve_taken_i(resolve_taken_i), .resolve_id_i(resolve_id_i),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i),
    .bht_update_o(bht_update_o), .full_o(full_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural model: a plain queue of in-flight branches, oldest first.
  typedef struct {
    logic [63:0] pc;
    logic        taken;
    logic [2:0]  id;
    bit          committed;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] m_emit_pc[$];
  logic [15:0] m_drop = '0;
  bht_update_t exp_upd = '0;
  logic        exp_full = 1'b0;
  logic [15:0] exp_drop = '0;
  bit          enq_done;
  bit          chk_en = 1'b0;
  int          checks = 0;
  int          failures = 0;
  int          dut_emits = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Single compare process: DUT outputs against the model every cycle.
  always @(negedge clk_i) begin
    if (bht_update_o.valid === 1'b1) dut_emits++;
    if (chk_en) begin
      check("upd_valid", 64'(bht_update_o.valid), 64'(exp_upd.valid));
      if (exp_upd.valid) begin
        check("upd_pc", bht_update_o.pc, exp_upd.pc);
        check("upd_taken", 64'(bht_update_o.taken), 64'(exp_upd.taken));
      end
      check("full", 64'(full_o), 64'(exp_full));
      check("drop_cnt", 64'(drop_cnt_o), 64'(exp_drop));
    end
  end

  // Drive one cycle of inputs (called at posedge+1), advance the model,
  // and return at the next posedge+1 with expectations updated.
  task automatic tick(input bit rv, input logic [63:0] pc, input bit tk, input logic [2:0] id,
                      input logic [1:0] cv, input logic [2:0] c0, input logic [2:0] c1,
                      input bit fl, input bit dbg);
    int pre;
    ent_t keep[$];
    ent_t e;
    bht_update_t nx;
    logic [2:0] cid[2];
    resolve_valid_i = rv; resolve_pc_i = pc; resolve_taken_i = tk; resolve_id_i = id;
    commit_valid_i = cv; commit_id_i[0] = c0; commit_id_i[1] = c1;
    flush_i = fl; debug_mode_i = dbg;
    cid[0] = c0; cid[1] = c1;
    for (int p = 0; p < 2; p++)
      if (cv[p])
        foreach (mq[i]) if (!mq[i].committed && mq[i].id == cid[p]) mq[i].committed = 1;
    pre = mq.size();
    nx = '0;
    if (pre > 0 && mq[0].committed) begin
      nx.valid = 1'b1; nx.pc = mq[0].pc; nx.taken = mq[0].taken;
      m_emit_pc.push_back(mq[0].pc);
      void'(mq.pop_front());
    end
    enq_done = 0;
    if (fl) begin
      foreach (mq[i]) if (mq[i].committed) keep.push_back(mq[i]);
      mq = keep;
    end else if (rv && !dbg) begin
      if (pre == DEPTH) begin
        if (m_drop != 16'hFFFF) m_drop++;
      end else begin
        e.pc = pc; e.taken = tk; e.id = id; e.committed = 0;
        mq.push_back(e);
        enq_done = 1;
      end
    end
    @(posedge clk_i); #1;
    exp_upd = nx; exp_full = (mq.size() == DEPTH); exp_drop = m_drop;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, '0, 0, 0, 2'b00, 0, 0, 0, 0);
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear at once.
  task automatic do_reset();
    chk_en = 0;
    #2 rst_ni = 1'b0;
    resolve_valid_i = 0; commit_valid_i = '0; flush_i = 0; debug_mode_i = 0;
    #1;
    check("rst_upd", 64'(bht_update_o), 64'd0);
    check("rst_full", 64'(full_o), 64'd0);
    check("rst_drop", 64'(drop_cnt_o), 64'd0);
    mq.delete(); m_drop = '0; exp_upd = '0; exp_full = 0; exp_drop = '0;
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;
    chk_en = 1;
  endtask

  initial begin
    int base;
    int fi;
    logic [63:0] stim_pc[20];
    logic [2:0] next_id;
    logic [2:0] nb;
    bit ok;
    bit rv, tk, fl, dbg;
    logic [1:0] cv;
    logic [2:0] c0, c1;
    logic [63:0] pc;

    // Reset state while reset has been held from time 0.
    #12;
    check("por_upd", 64'(bht_update_o), 64'd0);
    check("por_full", 64'(full_o), 64'd0);
    check("por_drop", 64'(drop_cnt_o), 64'd0);
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;
    chk_en = 1;

    // Single branch: update exactly one cycle after its commit.
    tick(1, 64'h80000010, 1, 3'd2, 2'b00, 0, 0, 0, 0);
    idle(1);
    tick(0, '0, 0, 0, 2'b01, 3'd2, 0, 0, 0);
    check("t1_model_pc", exp_upd.pc, 64'h80000010);
    check("t1_valid", 64'(bht_update_o.valid), 64'd1);
    check("t1_pc", bht_update_o.pc, 64'h80000010);
    check("t1_taken", 64'(bht_update_o.taken), 64'd1);
    idle(1);
    check("t1_valid_after", 64'(bht_update_o.valid), 64'd0);

    // Dual commit: two updates back to back, id 3 remains.
    do_reset();
    tick(1, 64'h100, 0, 3'd1, 2'b00, 0, 0, 0, 0);
    tick(1, 64'h200, 1, 3'd2, 2'b00, 0, 0, 0, 0);
    tick(1, 64'h300, 0, 3'd3, 2'b00, 0, 0, 0, 0);
    tick(0, '0, 0, 0, 2'b11, 3'd1, 3'd2, 0, 0);
    check("t2_first_pc", bht_update_o.pc, 64'h100);
    idle(1);
    check("t2_second_pc", bht_update_o.pc, 64'h200);
    check("t2_second_valid", 64'(bht_update_o.valid), 64'd1);
    idle(1);
    check("t2_then_idle", 64'(bht_update_o.valid), 64'd0);
    check("t2_model_left", 64'(mq.size()), 64'd1);

    // Flush with same-cycle commit and resolution.
    do_reset();
    base = dut_emits;
    tick(1, 64'h400, 1, 3'd4, 2'b00, 0, 0, 0, 0);
    tick(1, 64'h500, 0, 3'd5, 2'b00, 0, 0, 0, 0);
    tick(1, 64'h600, 1, 3'd6, 2'b01, 3'd4, 0, 1, 0);
    check("t3_pc", bht_update_o.pc, 64'h400);
    tick(0, '0, 0, 0, 2'b11, 3'd5, 3'd6, 0, 0);
    idle(3);
    check("t3_model_empty", 64'(mq.size()), 64'd0);
    check("t3_emits", 64'(dut_emits - base), 64'd1);

    // Fill, overflow by two, then drain everything intact.
    do_reset();
    base = dut_emits;
    for (int i = 0; i < 8; i++) tick(1, 64'h1000 + 64'(i * 4), i[0], 3'(i), 2'b00, 0, 0, 0, 0);
    check("t4_full", 64'(full_o), 64'd1);
    tick(1, 64'hDEAD0, 1, 3'd0, 2'b00, 0, 0, 0, 0);
    tick(1, 64'hDEAD1, 1, 3'd1, 2'b00, 0, 0, 0, 0);
    check("t4_drop", 64'(drop_cnt_o), 64'd2);
    check("t4_full2", 64'(full_o), 64'd1);
    for (int k = 0; k < 4; k++) tick(0, '0, 0, 0, 2'b11, 3'(2 * k), 3'(2 * k + 1), 0, 0);
    idle(6);
    check("t4_emits", 64'(dut_emits - base), 64'd8);

    // Debug mode: resolution ignored entirely.
    do_reset();
    base = dut_emits;
    tick(1, 64'h700, 1, 3'd1, 2'b00, 0, 0, 0, 1);
    tick(0, '0, 0, 0, 2'b01, 3'd1, 0, 0, 0);
    idle(2);
    check("t5_emits", 64'(dut_emits - base), 64'd0);
    check("t5_drop", 64'(drop_cnt_o), 64'd0);

    // 20 branches through with wrap-around and non-branch commits on port 1.
    do_reset();
    base = dut_emits;
    m_emit_pc.delete();
    for (int k = 0; k < 20; k++) begin
      stim_pc[k] = {$urandom, $urandom};
      tick(1, stim_pc[k], stim_pc[k][0], 3'(k), (k > 0) ? 2'b11 : 2'b10,
           3'(k - 1), 3'(k + 4), 0, 0);
    end
    tick(0, '0, 0, 0, 2'b01, 3'(19), 0, 0, 0);
    idle(3);
    check("t6_emits", 64'(dut_emits - base), 64'd20);
    for (int k = 0; k < 20; k++) check("t6_model_order", m_emit_pc[k], stim_pc[k]);

    // Randomized traffic with in-order commits, flushes and debug windows.
    do_reset();
    next_id = '0;
    for (int c = 0; c < 3000; c++) begin
      rv = ($urandom_range(0, 99) < 60);
      dbg = ($urandom_range(0, 99) < 3);
      fl = ($urandom_range(0, 99) < 3);
      pc = {$urandom, $urandom};
      tk = 1'($urandom);
      cv = '0; c0 = '0; c1 = '0;
      fi = -1;
      for (int i = 0; i < mq.size(); i++) if (fi < 0 && !mq[i].committed) fi = i;
      if (fi >= 0 && $urandom_range(0, 99) < 50) begin
        cv[0] = 1; c0 = mq[fi].id;
        if (fi + 1 < mq.size() && $urandom_range(0, 1) == 1) begin cv[1] = 1; c1 = mq[fi + 1].id; end
      end else if ($urandom_range(0, 99) < 30) begin
        nb = 3'($urandom);
        ok = 1;
        foreach (mq[i]) if (!mq[i].committed && mq[i].id == nb) ok = 0;
        if (ok) begin cv[1] = 1; c1 = nb; end
      end
      tick(rv, pc, tk, next_id, cv, c0, c1, fl, dbg);
      if (enq_done) next_id = next_id + 3'd1;
      if (c == 1500) begin
        do_reset();
        next_id = '0;
      end
    end
    idle(2);

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
